// File: rtl/pcie_xadm_client_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_xadm_client_arb
//  Purpose  : Round-robin arbiter/sequencer sharing the single xadm TLP
//             submission path among NCL outbound clients. One client owns
//             the path for a whole TLP (header through end-of-transaction);
//             a watchdog revokes ownership from a client that stops moving.
//  Ports    : clk, rst_n                  clock, async active-low reset
//             client_tlp_hv/hdr/dv/data/byte_en/eot   packed per-client TLP
//             client_halt                 per-client stall (1 = stall)
//             xadm_ready                  xadm accepts a beat this cycle
//             xadm_tlp_hv/dv/eot/hdr/data/byte_en     forwarded owner TLP
//             arb_grant                   one-hot current owner (0 = idle)
//             arb_timeout                 one-cycle watchdog revoke pulse
//  Revision : 1.0  initial release
// ============================================================================
module pcie_xadm_client_arb #(
   parameter int NCL     = 2,
   parameter int HDR_WD  = 89,
   parameter int DATA_WD = 64,
   parameter int TO_CYC  = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NCL-1:0]             client_tlp_hv,
   input  logic [NCL*HDR_WD-1:0]      client_tlp_hdr,
   input  logic [NCL-1:0]             client_tlp_dv,
   input  logic [NCL*DATA_WD-1:0]     client_tlp_data,
   input  logic [NCL*(DATA_WD/8)-1:0] client_tlp_byte_en,
   input  logic [NCL-1:0]             client_tlp_eot,
   output logic [NCL-1:0]             client_halt,
   input  logic                       xadm_ready,
   output logic                       xadm_tlp_hv,
   output logic                       xadm_tlp_dv,
   output logic                       xadm_tlp_eot,
   output logic [HDR_WD-1:0]          xadm_tlp_hdr,
   output logic [DATA_WD-1:0]         xadm_tlp_data,
   output logic [(DATA_WD/8)-1:0]     xadm_tlp_byte_en,
   output logic [NCL-1:0]             arb_grant,
   output logic                       arb_timeout
);

   localparam int c_strb_wd = DATA_WD / 8;
   localparam int c_ow      = (NCL > 2) ? 2 : 1;   // owner index width
   localparam int c_wd_w    = $clog2(TO_CYC);      // watchdog counter width

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_t;

   arb_state_t          r_state;
   logic [c_ow-1:0]     r_owner;
   logic [c_ow-1:0]     r_last_ptr;
   logic [NCL-1:0]      r_grant;
   logic [c_wd_w-1:0]   r_wdog;

   logic [c_ow-1:0]     w_pick;
   logic                w_pick_vld;
   logic [c_ow-1:0]     w_idx;
   logic                w_own;
   logic                w_own_hv;
   logic                w_own_dv;
   logic                w_own_eot;
   logic                w_acc_hv;
   logic                w_acc_dv;
   logic                w_acc_eot;
   logic                w_beat;
   logic                w_release;
   logic                w_expire;

   // Round-robin search upward from last_ptr+1. Scanning from the farthest
   // candidate down lets the nearest requester overwrite earlier hits.
   always_comb begin
      w_pick     = '0;
      w_pick_vld = 1'b0;
      w_idx      = '0;
      for (int k = NCL; k >= 1; k--) begin
         w_idx = c_ow'((int'(r_last_ptr) + k) % NCL);
         if (client_tlp_hv[w_idx]) begin
            w_pick     = w_idx;
            w_pick_vld = 1'b1;
         end
      end
   end

   assign w_own     = (r_state == ARB_OWN);
   assign w_own_hv  = client_tlp_hv[r_owner];
   assign w_own_dv  = client_tlp_dv[r_owner];
   assign w_own_eot = client_tlp_eot[r_owner];

   assign w_acc_hv  = w_own & w_own_hv  & xadm_ready;
   assign w_acc_dv  = w_own & w_own_dv  & xadm_ready;
   assign w_acc_eot = w_own & w_own_eot & xadm_ready;
   assign w_beat    = w_acc_hv | w_acc_dv | w_acc_eot;

   // A header-only eot (no dv) never releases; only the watchdog can.
   assign w_release = w_acc_dv & w_acc_eot;
   assign w_expire  = w_own & ~w_beat & (r_wdog == c_wd_w'(TO_CYC - 1));

   assign xadm_tlp_hv      = w_acc_hv;
   assign xadm_tlp_dv      = w_acc_dv;
   assign xadm_tlp_eot     = w_acc_eot;
   assign xadm_tlp_hdr     = w_own ? client_tlp_hdr[int'(r_owner)*HDR_WD +: HDR_WD]        : '0;
   assign xadm_tlp_data    = w_own ? client_tlp_data[int'(r_owner)*DATA_WD +: DATA_WD]     : '0;
   assign xadm_tlp_byte_en = w_own ? client_tlp_byte_en[int'(r_owner)*c_strb_wd +: c_strb_wd] : '0;
   assign arb_grant        = r_grant;
   assign arb_timeout      = w_expire;

   always_comb begin
      client_halt = '1;
      if (w_own) begin
         client_halt[r_owner] = ~xadm_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_owner    <= '0;
         r_last_ptr <= c_ow'(NCL - 1);   // client0 wins the first tie
         r_grant    <= '0;
         r_wdog     <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_vld) begin
                  r_owner <= w_pick;
                  r_grant <= NCL'(1) << w_pick;
                  r_wdog  <= '0;
                  r_state <= ARB_OWN;
               end
            end
            ARB_OWN: begin
               if (w_release || w_expire) begin
                  r_last_ptr <= r_owner;
                  r_grant    <= '0;
                  r_wdog     <= '0;
                  r_state    <= ARB_IDLE;
               end else if (w_beat) begin
                  r_wdog <= '0;
               end else if (r_wdog != c_wd_w'(TO_CYC - 1)) begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pcie_xadm_client_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_xadm_client_arb
//  Purpose  : Self-checking bench for pcie_xadm_client_arb (two clients,
//             16-cycle watchdog). A protocol-level model tracks owner, last
//             winner and idle-cycle count and predicts all outputs per cycle;
//             directed scenarios add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcie_xadm_client_arb;

   localparam int NCL     = 2;
   localparam int HDR_WD  = 89;
   localparam int DATA_WD = 64;
   localparam int STRB_WD = 8;
   localparam int TO_CYC  = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCL-1:0]     hv, dv, eot;
   logic [HDR_WD-1:0]  hdr  [NCL];
   logic [DATA_WD-1:0] data [NCL];
   logic [STRB_WD-1:0] be   [NCL];
   logic               ready;

   logic [NCL*HDR_WD-1:0]  client_tlp_hdr;
   logic [NCL*DATA_WD-1:0] client_tlp_data;
   logic [NCL*STRB_WD-1:0] client_tlp_byte_en;
   assign client_tlp_hdr     = {hdr[1], hdr[0]};
   assign client_tlp_data    = {data[1], data[0]};
   assign client_tlp_byte_en = {be[1], be[0]};

   logic [NCL-1:0]     halt;
   logic               xhv, xdv, xeot;
   logic [HDR_WD-1:0]  xhdr;
   logic [DATA_WD-1:0] xdata;
   logic [STRB_WD-1:0] xbe;
   logic [NCL-1:0]     grant;
   logic               tout;

   pcie_xadm_client_arb #(
      .NCL(NCL), .HDR_WD(HDR_WD), .DATA_WD(DATA_WD), .TO_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .client_tlp_hv(hv), .client_tlp_hdr(client_tlp_hdr),
      .client_tlp_dv(dv), .client_tlp_data(client_tlp_data),
      .client_tlp_byte_en(client_tlp_byte_en), .client_tlp_eot(eot),
      .client_halt(halt), .xadm_ready(ready),
      .xadm_tlp_hv(xhv), .xadm_tlp_dv(xdv), .xadm_tlp_eot(xeot),
      .xadm_tlp_hdr(xhdr), .xadm_tlp_data(xdata), .xadm_tlp_byte_en(xbe),
      .arb_grant(grant), .arb_timeout(tout)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [HDR_WD-1:0] mk_hdr(input logic [63:0] addr, input logic [12:0] len);
      return {2'b11, 5'b00000, 3'd0, 2'd0, len, addr};
   endfunction

   // ---------------- protocol model ----------------
   logic     m_busy;
   logic     m_own;
   logic     m_last;
   int       m_idle;

   always @(negedge clk) begin : cmp
      logic [NCL-1:0]     e_halt, e_grant;
      logic [2:0]         e_strb;
      logic [HDR_WD-1:0]  e_hdr;
      logic [71:0]        e_pay;
      logic               e_to, beat;
      logic [0:0]         cand;
      logic               found;
      if (!rst_n) begin
         m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_idle = 0;
      end
      e_halt = '1; e_grant = '0; e_strb = '0; e_hdr = '0; e_pay = '0; e_to = 1'b0; beat = 1'b0;
      if (m_busy) begin
         e_halt[m_own]  = !ready;
         e_grant[m_own] = 1'b1;
         e_strb = {hv[m_own], dv[m_own], eot[m_own]} & {3{ready}};
         beat   = |e_strb;
         e_hdr  = hdr[m_own];
         e_pay  = {data[m_own], be[m_own]};
         e_to   = !beat && (m_idle == TO_CYC - 1);
      end
      chk("cyc_grant",   grant, e_grant);
      chk("cyc_halt",    halt, e_halt);
      chk("cyc_strobes", {xhv, xdv, xeot}, e_strb);
      chk("cyc_hdr",     xhdr, e_hdr);
      chk("cyc_payload", {xdata, xbe}, e_pay);
      chk("cyc_timeout", tout, e_to);
      if (rst_n) begin
         if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= NCL; k++) begin
               cand = m_last + 1'(k);
               if (!found && hv[cand]) begin
                  found = 1'b1; m_busy = 1'b1; m_own = cand; m_idle = 0;
               end
            end
         end else if (ready && dv[m_own] && eot[m_own]) begin
            m_last = m_own; m_busy = 1'b0;
         end else if (beat) begin
            m_idle = 0;
         end else if (m_idle == TO_CYC - 1) begin
            m_last = m_own; m_busy = 1'b0;
         end else begin
            m_idle++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_edge;
      @(posedge clk); #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      hv = '0; dv = '0; eot = '0;
      for (int i = 0; i < NCL; i++) begin
         hdr[i] = '0; data[i] = '0; be[i] = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [0:0] o;
      int         w;
      int         tcyc;
      rst_n = 1'b0; ready = 1'b1; clear_inputs();

      // reset state
      drive_edge(); drive_edge(); sample();
      chk("rst_halt", halt, 2'b11);
      chk("rst_grant", grant, 2'b00);
      chk("rst_strobes", {xhv, xdv, xeot, tout}, 4'b0);
      chk("rst_hdr", xhdr, '0);
      drive_edge(); rst_n = 1'b1;

      // single request from client0
      drive_edge(); hv[0] = 1'b1; hdr[0] = mk_hdr(64'h1000_0000, 13'd16); sample();
      chk("t1_idle_grant", grant, 2'b00);
      chk("t1_idle_halt", halt, 2'b11);
      drive_edge(); sample();
      chk("t1_grant", grant, 2'b01);
      chk("t1_halt", halt, 2'b10);
      chk("t1_xhv", xhv, 1'b1);
      chk("t1_addr", xhdr[63:0], 64'h1000_0000);
      drive_edge(); hv[0] = 1'b0; dv[0] = 1'b1; data[0] = 64'hA1; be[0] = 8'hFF; sample();
      chk("t1_beat1", {xdv, xeot, xdata}, {1'b1, 1'b0, 64'hA1});
      drive_edge(); eot[0] = 1'b1; data[0] = 64'hA2; sample();
      chk("t1_beat2", {xdv, xeot, xdata}, {1'b1, 1'b1, 64'hA2});
      drive_edge(); dv[0] = 1'b0; eot[0] = 1'b0; sample();
      chk("t1_release", {grant, halt}, 4'b0011);

      // contention from reset
      drive_edge(); rst_n = 1'b0;
      drive_edge(); rst_n = 1'b1;
      drive_edge(); hv = 2'b11; hdr[1] = mk_hdr(64'h2000_0000, 13'd8); sample();
      drive_edge(); sample();
      chk("t2_first", grant, 2'b01);
      drive_edge(); hv[0] = 1'b0; dv[0] = 1'b1; eot[0] = 1'b1; data[0] = 64'hB0; sample();
      chk("t2_halt1_held", halt[1], 1'b1);
      chk("t2_c0_eot", xeot, 1'b1);
      drive_edge(); dv[0] = 1'b0; eot[0] = 1'b0; sample();
      chk("t2_bubble", grant, 2'b00);
      drive_edge(); sample();
      chk("t2_grant1", {grant, halt}, 4'b1001);
      chk("t2_addr1", xhdr[63:0], 64'h2000_0000);
      drive_edge(); hv[1] = 1'b0; dv[1] = 1'b1; eot[1] = 1'b1; data[1] = 64'hB1;
      drive_edge(); dv[1] = 1'b0; eot[1] = 1'b0;

      // fairness over 8 TLPs
      drive_edge(); hv = 2'b11;
      for (int t = 0; t < 8; t++) begin
         w = 0;
         sample();
         while (grant == 2'b00 && w < 8) begin
            drive_edge(); sample(); w++;
         end
         chk("rr_order", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
         o = grant[1];
         drive_edge(); hv[o] = 1'b0; dv[o] = 1'b1; eot[o] = 1'b1; data[o] = 64'(t);
         if (t == 7) hv = 2'b00;
         drive_edge(); dv[o] = 1'b0; eot[o] = 1'b0;
         if (t < 7) hv[o] = 1'b1;
      end

      // back-pressure mid-burst
      drive_edge(); hv[0] = 1'b1; hdr[0] = mk_hdr(64'h3000_0000, 13'd32);
      drive_edge();
      drive_edge(); hv[0] = 1'b0; dv[0] = 1'b1; data[0] = 64'hC1; be[0] = 8'h0F;
      drive_edge(); data[0] = 64'hC2; be[0] = 8'hF0; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("bp_halt", halt, 2'b11);
         chk("bp_strobes", {xhv, xdv, xeot}, 3'b000);
         chk("bp_grant", grant, 2'b01);
         drive_edge();
      end
      ready = 1'b1; eot[0] = 1'b1; sample();
      chk("bp_resume", {xdv, xeot, xdata, xbe}, {1'b1, 1'b1, 64'hC2, 8'hF0});
      drive_edge(); dv[0] = 1'b0; eot[0] = 1'b0;

      // watchdog: client1 granted then idles, client0 waiting
      drive_edge(); hv[1] = 1'b1; hdr[1] = mk_hdr(64'h4000_0000, 13'd4); sample();
      drive_edge(); sample();
      chk("wd_grant1", grant, 2'b10);
      drive_edge(); hv[1] = 1'b0; hv[0] = 1'b1; hdr[0] = mk_hdr(64'h5000_0000, 13'd32);
      tcyc = -1;
      for (int k = 1; k <= 24; k++) begin
         sample();
         if (tout) begin
            tcyc = k;
            break;
         end
         drive_edge();
      end
      chk("wd_cycle", 32'(tcyc), 32'd16);
      drive_edge(); sample();
      chk("wd_release", grant, 2'b00);
      drive_edge(); sample();
      chk("wd_next", grant, 2'b01);

      // reset during beat 2 of 4
      drive_edge(); hv[0] = 1'b0; dv[0] = 1'b1; data[0] = 64'hD1;
      drive_edge(); data[0] = 64'hD2;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_halt", halt, 2'b11);
      chk("rst_async_grant", grant, 2'b00);
      chk("rst_async_strobes", {xhv, xdv, xeot}, 3'b000);
      clear_inputs();
      drive_edge(); drive_edge(); rst_n = 1'b1;
      drive_edge(); hv = 2'b11; sample();
      drive_edge(); sample();
      chk("rst_first_winner", grant, 2'b01);
      drive_edge(); hv = 2'b00; dv[0] = 1'b1; eot[0] = 1'b1;
      drive_edge(); dv[0] = 1'b0; eot[0] = 1'b0;
      repeat (3) drive_edge();
      sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pcie_xadm_client_arb.md
# pcie_xadm_client_arb

Round-robin arbiter and sequencer that shares the single xadm TLP submission path among NCL outbound clients (client0 = AXI slave write controller, client1 = slave read-request controller, further clients optional). It watches each client's header-valid request, grants one client at a time for a whole TLP (header through end-of-transaction), drives each client's halt back-pressure, and muxes the granted client's TLP fields onto the xadm port. A watchdog releases a grant whose owner stalls, so one faulty client cannot lock the path.

## Interface
- NCL, 2, number of clients (legal 2..4)
- HDR_WD, 89, packed header width per client: {fmt[1:0], type[4:0], tc[2:0], attr[1:0], byte_len[12:0], addr[63:0]}
- DATA_WD, 64, TLP data width; STRB_WD = DATA_WD/8
- TO_CYC, 256, watchdog limit in cycles (power of two, ≥4)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- client_tlp_hv  in  NCL  per-client header valid (held while waiting for grant)
- client_tlp_hdr  in  NCL*HDR_WD  packed headers, client i at [i*HDR_WD +: HDR_WD]
- client_tlp_dv  in  NCL  per-client data valid
- client_tlp_data  in  NCL*DATA_WD  per-client data
- client_tlp_byte_en  in  NCL*STRB_WD  per-client byte enables
- client_tlp_eot  in  NCL  per-client end of TLP
- client_halt  out  NCL  per-client back-pressure (1 = stall)
- xadm_ready  in  1  xadm core can accept a beat this cycle
- xadm_tlp_hv / xadm_tlp_dv / xadm_tlp_eot  out  1 each  forwarded strobes
- xadm_tlp_hdr  out  HDR_WD  forwarded header
- xadm_tlp_data  out  DATA_WD;  xadm_tlp_byte_en  out  STRB_WD
- arb_grant  out  NCL  one-hot current owner (0 when idle)
- arb_timeout  out  1  one-cycle pulse when watchdog revokes a grant

## Operation
- FSM states: ARB_IDLE, ARB_OWN.
- ARB_IDLE: all client_halt = 1, all xadm strobes 0. If any client_tlp_hv = 1, pick winner by round-robin: first requester searching upward (mod NCL) from last_ptr+1. Register owner, arb_grant one-hot, go ARB_OWN. No request: stay.
- ARB_OWN: client_halt[owner] = !xadm_ready; all others 1. xadm_tlp_hv/dv/eot = client strobe[owner] & xadm_ready; hdr/data/byte_en = owner slice (combinational mux). Non-owner strobes ignored.
- Release: owner dv & eot & xadm_ready -> last_ptr <= owner, arb_grant <= 0, state ARB_IDLE.
- Watchdog: counter cleared on grant and on every forwarded beat (any strobe & xadm_ready from owner); increments otherwise in ARB_OWN. At TO_CYC-1 -> arb_timeout pulse, last_ptr <= owner, back to ARB_IDLE. Counter saturates; never wraps.
- Header-only eot (eot without dv) does not release; only watchdog recovers.
- Reset state: ARB_IDLE, last_ptr = NCL-1 (client0 wins first tie), arb_grant 0, client_halt all 1, xadm strobes 0, xadm_tlp_hdr/data/byte_en 0 (mux selects nothing), arb_timeout 0, watchdog 0.

## Timing
- Grant latency: hv seen in IDLE cycle N -> owner registered at edge end of N -> halt[owner] low in N+1 if xadm_ready.
- Outputs combinational from owner register, client inputs and xadm_ready; no added datapath latency.
- Release to next grant: eot accepted cycle M -> IDLE in M+1 (arbitration) -> next owner halt low in M+2. One-cycle bubble mandatory.
- Simultaneous requests: strict RR; with both clients hv continuously, grants alternate 0,1,0,1.
- Requester dropping hv while IDLE: not granted; hv dropping after grant does not cancel ownership.
- xadm_ready low mid-TLP: owner halted, strobes 0, grant held, watchdog counts.
- rst_n asserted mid-TLP: immediate return to reset values; partial TLP discarded, no eot emitted.

## Test plan
- Single request: client0 hv=1, hdr addr=0x1000_0000, 2 dv beats, eot on 2nd, xadm_ready=1 -> halt0 low from cycle 2, xadm_hv/dv mirror client0, arb_grant=01 then 00 after eot.
- Contention: both hv=1 from reset -> client0 granted first; after client0 eot, client1 granted exactly 2 cycles later; client1 halt=1 throughout client0 ownership.
- Fairness: both request continuously for 8 TLPs -> grant order 0,1,0,1,0,1,0,1.
- Back-pressure: xadm_ready=0 for 5 cycles mid-burst -> halt[owner]=1, no xadm strobes, data beat forwarded unchanged when ready returns.
- Watchdog: TO_CYC=16, client1 granted then idles -> arb_timeout pulses at cycle 16 after last beat, arb_grant=00, client0 pending request granted next.
- Reset mid-TLP: rst_n low during beat 2 of 4 -> all halts 1, arb_grant 0, strobes 0 asynchronously; after release client0 wins first.
